// File: rtl/uart_rx_monitor_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_monitor_pkg
// Shared definitions for the uart_rx_monitor receiver:
//   - rx_state_e : receiver FSM states
//   - OS_RATE    : oversampling factor (samples per bit)
//   - SMP_*      : sample-counter positions used for the 3-sample vote and
//                  for the end of a bit period
//   - majority3  : 2-of-3 vote helper
// ----------------------------------------------------------------------------
package uart_rx_monitor_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BRK    = 3'd5
    } rx_state_e;

    localparam int OS_RATE = 16;

    // Samples 7, 8 and 9 straddle the bit centre; the decision is taken
    // on the tick that ends sample 9, using the two stored samples plus
    // the live synchronized line.
    localparam logic [3:0] SMP_FIRST = 4'd7;
    localparam logic [3:0] SMP_MID   = 4'd8;
    localparam logic [3:0] SMP_VOTE  = 4'd9;
    localparam logic [3:0] SMP_LAST  = 4'd15;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
// First-word-fall-through FIFO: head_o always shows the oldest entry.
// Written generically so a transmit-side driver can reuse it.
//
// Ports:
//   clk          in   clock
//   rst_n        in   synchronous active-low reset (flushes the FIFO)
//   push_i       in   write push_data_i (dropped when full, unless popping)
//   push_data_i  in   WIDTH-bit write data
//   pop_i        in   remove head entry (ignored when empty)
//   full_o       out  FIFO holds FIFO_DEPTH entries
//   empty_o      out  FIFO holds no entries
//   head_o       out  oldest entry; reads 0 while empty
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];

    // One extra pointer bit separates "full" from "empty" when the
    // address bits coincide.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a push to a full FIFO
    // is still accepted then.
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_rx_monitor.sv
// ----------------------------------------------------------------------------
// uart_rx_monitor
// 16x-oversampling UART receiver (8N1 by default) with a FWFT byte FIFO and
// a valid/ready consumer interface. Each bit is decided by a 2-of-3 vote of
// the samples at positions 7, 8 and 9.
//
// Build option:
//   UART_RX_PARITY_EN  defined   -> 8E1 frames, parity checked, parity_err_o
//                      undefined -> 8N1 frames, parity_err_o tied to 0
//
// Ports:
//   clk           in   system clock
//   rst_n         in   synchronous active-low reset
//   rx_i          in   asynchronous serial line, idle high
//   data_o        out  FIFO head byte (valid while valid_o=1)
//   valid_o       out  FIFO non-empty
//   ready_i       in   consumer takes data_o when valid_o & ready_i
//   frame_err_o   out  one-cycle pulse: stop bit sampled low
//   parity_err_o  out  one-cycle pulse: parity mismatch
//   overflow_o    out  sticky: good byte arrived while FIFO full
//   clear_i       in   clears overflow_o (a simultaneous new overflow wins)
// ----------------------------------------------------------------------------
module uart_rx_monitor
    import uart_rx_monitor_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD        = 115200,
    parameter int OS_DIV      = CLK_FREQ_HZ / (BAUD * OS_RATE),
    parameter int FIFO_DEPTH  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       parity_err_o,
    output logic       overflow_o,
    input  logic       clear_i
);

    localparam int OS_W = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;

    logic            rx_meta_q;
    logic            rx_s_q;
    logic [1:0]      warm_q;
    logic            line_seen_high_q;

    rx_state_e       state_q, state_d;
    logic [OS_W-1:0] os_cnt_q, os_cnt_d;
    logic [3:0]      s_q, s_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [1:0]      smp_q, smp_d;
    logic            frame_err_q, frame_err_d;
    logic            overflow_q, overflow_d;

    logic            tick;
    logic            vote;
    logic            vote_now;
    logic            end_now;
    logic            push;
    logic            pop;
    logic            par_bad;
    logic            fifo_full;
    logic            fifo_empty;

`ifdef UART_RX_PARITY_EN
    logic            par_bit_q, par_bit_d;
    logic            parity_err_q, parity_err_d;

    // Even parity: the received parity bit must equal the XOR of the data.
    assign par_bad = par_bit_q ^ (^shift_q);
`else
    assign par_bad = 1'b0;
`endif

    assign tick     = (os_cnt_q == OS_W'(OS_DIV - 1));
    assign vote     = majority3(smp_q[0], smp_q[1], rx_s_q);
    assign vote_now = tick && (s_q == SMP_VOTE);
    assign end_now  = tick && (s_q == SMP_LAST);

    always_comb begin
        state_d     = state_q;
        os_cnt_d    = tick ? '0 : os_cnt_q + OS_W'(1);
        s_d         = s_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        smp_d       = smp_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif

        if (state_q != IDLE && tick) begin
            s_d = s_q + 4'd1;
        end
        if (tick && s_q == SMP_FIRST) begin
            smp_d[0] = rx_s_q;
        end
        if (tick && s_q == SMP_MID) begin
            smp_d[1] = rx_s_q;
        end

        case (state_q)
            IDLE: begin
                // line_seen_high_q blocks a start on a line that was already
                // low when reset released; a fresh falling edge is needed.
                if (line_seen_high_q && !rx_s_q) begin
                    state_d  = START;
                    os_cnt_d = '0;
                    s_d      = '0;
                    shift_d  = '0;
                end
            end
            START: begin
                if (vote_now && vote) begin
                    state_d = IDLE;
                end else if (end_now) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (vote_now) begin
                    shift_d = {vote, shift_q[7:1]};
                end
                if (end_now) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (vote_now) begin
                    par_bit_d = vote;
                end
                if (end_now) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Leave at the stop-bit centre so the next start edge of a
                // back-to-back frame is not missed.
                if (vote_now) begin
`ifdef UART_RX_PARITY_EN
                    parity_err_d = par_bad;
`endif
                    if (!vote) begin
                        frame_err_d = 1'b1;
                        state_d     = BRK;
                    end else begin
                        push    = ~par_bad;
                        state_d = IDLE;
                    end
                end
            end
            BRK: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pop        = ready_i & ~fifo_empty;
    assign overflow_d = (push & fifo_full & ~pop) | (overflow_q & ~clear_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q        <= 1'b1;
            rx_s_q           <= 1'b1;
            warm_q           <= 2'b00;
            line_seen_high_q <= 1'b0;
            state_q          <= IDLE;
            os_cnt_q         <= '0;
            s_q              <= '0;
            bit_idx_q        <= '0;
            shift_q          <= '0;
            smp_q            <= '0;
            frame_err_q      <= 1'b0;
            overflow_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q        <= 1'b0;
            parity_err_q     <= 1'b0;
`endif
        end else begin
            rx_meta_q        <= rx_i;
            rx_s_q           <= rx_meta_q;
            // The synchronizer reflects the real line two cycles after reset.
            warm_q           <= {warm_q[0], 1'b1};
            line_seen_high_q <= line_seen_high_q | (warm_q[1] & rx_s_q);
            state_q          <= state_d;
            os_cnt_q         <= os_cnt_d;
            s_q              <= s_d;
            bit_idx_q        <= bit_idx_d;
            shift_q          <= shift_d;
            smp_q            <= smp_d;
            frame_err_q      <= frame_err_d;
            overflow_q       <= overflow_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q        <= par_bit_d;
            parity_err_q     <= parity_err_d;
`endif
        end
    end

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (8)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (shift_q),
        .pop_i       (ready_i),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (data_o)
    );

    assign valid_o     = ~fifo_empty;
    assign frame_err_o = frame_err_q;
    assign overflow_o  = overflow_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_monitor.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_monitor
// Drives serial frames into uart_rx_monitor and checks received bytes, error
// pulses and overflow against a queue-based model of what was sent.
// Clock rate is scaled so one bit is 64 clocks (OS_DIV = 4).
// ----------------------------------------------------------------------------
module tb_uart_rx_monitor;

    localparam int CLK_HZ     = 7372800;
    localparam int BAUD_R     = 115200;
    localparam int BIT_CLK    = 16 * (CLK_HZ / (BAUD_R * 16));
    localparam int DEPTH      = 16;
    localparam int MAX_CYCLES = 95000;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif
    localparam int LAT_LO = NBITS * BIT_CLK + BIT_CLK / 4;
    localparam int LAT_HI = (NBITS + 1) * BIT_CLK;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx_i    = 1'b1;
    logic       ready_i = 1'b0;
    logic       clear_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       parity_err_o;
    logic       overflow_o;

    uart_rx_monitor #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD        (BAUD_R),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (rx_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .overflow_o   (overflow_o),
        .clear_i      (clear_i)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model
    logic [7:0]  exp_q[$];
    logic        exp_ovf = 1'b0;
    int          exp_fe  = 0;
    int          exp_pe  = 0;

    // Observations
    int          fe_cnt = 0;
    int          pe_cnt = 0;
    int          pop_cnt = 0;
    int          valid_rise_cyc = 0;
    int          frame_start_cyc = 0;
    logic        valid_prev = 1'b0;
    bit          rand_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (frame_err_o)  fe_cnt++;
            if (parity_err_o) pe_cnt++;
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("spurious_pop", 32'(valid_o), 32'd0);
                end else begin
                    check("pop_data", 32'(data_o), 32'(exp_q.pop_front()));
                    pop_cnt++;
                end
            end
            if (valid_o && !valid_prev) valid_rise_cyc = cyc;
            valid_prev = valid_o;
        end else begin
            valid_prev = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) ready_i = 1'($urandom_range(0, 1));
    end

    initial begin
        repeat (MAX_CYCLES) @(posedge clk);
        $display("FAIL watchdog: exceeded %0d cycles", MAX_CYCLES);
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx_i = v;
        wait_clks(BIT_CLK);
    endtask

    // Sends one frame; line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        bit good;
`ifdef UART_RX_PARITY_EN
        good = stop_ok && par_ok;
        if (!par_ok) exp_pe++;
`else
        good = stop_ok;
`endif
        if (!stop_ok) exp_fe++;
        if (good) begin
            if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
            else exp_q.push_back(b);
        end
        $display("tx 0x%02h stop=%0d par_ok=%0d", b, stop_ok, par_ok);
        frame_start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ ~par_ok);
`endif
        drive_bit(stop_ok);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 8 * BIT_CLK) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        wait_clks(n);
        exp_q.delete();
        exp_ovf = 1'b0;
        check("rst_data",      32'(data_o),       32'd0);
        check("rst_valid",     32'(valid_o),      32'd0);
        check("rst_frame_err", 32'(frame_err_o),  32'd0);
        check("rst_par_err",   32'(parity_err_o), 32'd0);
        check("rst_overflow",  32'(overflow_o),   32'd0);
        rst_n = 1'b1;
    endtask

    task automatic check_err_counts(input string tag);
        check({tag, "_fe_cnt"}, 32'(fe_cnt), 32'(exp_fe));
        check({tag, "_pe_cnt"}, 32'(pe_cnt), 32'(exp_pe));
    endtask

    initial begin
        int p0;
        int lat;
        logic [7:0] b;
        bit stop_ok;
        bit par_ok;

        wait_clks(1);
        do_reset(4);
        wait_clks(8);

        // Single byte, latency measured from the start edge.
        ready_i = 1'b0;
        send_frame(8'h55, 1'b1, 1'b1);
        wait_clks(2);
        check("t1_valid", 32'(valid_o), 32'd1);
        check("t1_data", 32'(data_o), 32'(exp_q[0]));
        lat = valid_rise_cyc - frame_start_cyc;
        check("t1_latency_window", 32'(lat >= LAT_LO && lat <= LAT_HI), 32'd1);
        ready_i = 1'b1;
        wait_drain("t1_drain");
        check_err_counts("t1");

        // Back-to-back frames, consumer always ready.
        p0 = pop_cnt;
        send_frame(8'hA3, 1'b1, 1'b1);
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        wait_drain("t2_drain");
        check("t2_pops", 32'(pop_cnt - p0), 32'd3);
        check_err_counts("t2");

        // Overflow: 17 bytes with the consumer stalled.
        ready_i = 1'b0;
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, 1'b1);
            if (i == 15) check("t3_ovf_at_full", 32'(overflow_o), 32'(exp_ovf));
        end
        wait_clks(4);
        check("t3_ovf_set", 32'(overflow_o), 32'(exp_ovf));
        check("t3_head", 32'(data_o), 32'(exp_q[0]));
        ready_i = 1'b1;
        wait_drain("t3_drain");
        check("t3_ovf_sticky", 32'(overflow_o), 32'(exp_ovf));
        clear_i = 1'b1;
        wait_clks(1);
        clear_i = 1'b0;
        exp_ovf = 1'b0;
        check("t3_ovf_cleared", 32'(overflow_o), 32'(exp_ovf));

        // Short low glitch on an idle line.
        rx_i = 1'b0;
        wait_clks(3);
        rx_i = 1'b1;
        wait_clks(2 * BIT_CLK);
        check("t4_no_valid", 32'(valid_o), 32'd0);
        check_err_counts("t4");
        send_frame(8'h42, 1'b1, 1'b1);
        wait_drain("t4_drain");

        // Stop bit low followed by a held-low line.
        p0 = pop_cnt;
        send_frame(8'h3C, 1'b0, 1'b1);
        wait_clks(3 * BIT_CLK);
        rx_i = 1'b1;
        wait_clks(BIT_CLK);
        check("t5_no_push", 32'(pop_cnt - p0), 32'd0);
        check_err_counts("t5");
        send_frame(8'h81, 1'b1, 1'b1);
        wait_drain("t5_drain");

`ifdef UART_RX_PARITY_EN
        // Wrong parity then correct parity.
        ready_i = 1'b0;
        send_frame(8'h07, 1'b1, 1'b0);
        wait_clks(2);
        check("t6_bad_par_no_valid", 32'(valid_o), 32'd0);
        check_err_counts("t6");
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clks(2);
        check("t6_good_par_data", 32'(data_o), 32'(exp_q[0]));
        ready_i = 1'b1;
        wait_drain("t6_drain");
`endif

        // Reset mid-frame with the line still low across release.
        ready_i = 1'b1;
        rx_i = 1'b0;
        wait_clks(3 * BIT_CLK);
        do_reset(5);
        wait_clks(2 * BIT_CLK);
        rx_i = 1'b1;
        wait_clks(11 * BIT_CLK);
        check("t7_no_restart", 32'(valid_o), 32'd0);
        check_err_counts("t7");
        send_frame(8'h5A, 1'b1, 1'b1);
        wait_drain("t7_drain");

        // Randomized frames, random consumer stalls and gaps.
        rand_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            b       = 8'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
            par_ok  = ($urandom_range(0, 5) != 0);
`else
            par_ok  = 1'b1;
`endif
            send_frame(b, stop_ok, par_ok);
            if (!stop_ok) begin
                rx_i = 1'b1;
                wait_clks(BIT_CLK);
            end
            wait_clks($urandom_range(0, 2 * BIT_CLK));
        end
        rand_ready = 1'b0;
        ready_i = 1'b1;
        wait_drain("t8_drain");
        wait_clks(4);
        check("t8_final_valid", 32'(valid_o), 32'd0);
        check("t8_final_ovf", 32'(overflow_o), 32'(exp_ovf));
        check_err_counts("t8");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
